// File: rtl/roll_scan_pkg.sv
// Shared definitions for the roll_scan prefix-sum unit: FSM state encoding and in_mode bit positions.
package roll_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MODE_SAT   = 0;
  localparam int MODE_CHAIN = 1;

  // Lane counter width; a single lane still gets a 1-bit counter.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/roll_lane_add.sv
// Combinational lane adder: a+b formed one bit wider, then wrapped or clamped to all-ones.
module roll_lane_add
  import roll_scan_pkg::*;
#(
  parameter int LANE_W = 4
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic              sat,
  output logic [LANE_W-1:0] y
);

  function automatic logic [LANE_W-1:0] sat_lane(input logic [LANE_W:0] s, input logic sat_en);
    if (s[LANE_W] && sat_en) return '1;
    return s[LANE_W-1:0];
  endfunction

  logic [LANE_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};
  assign y   = sat_lane(sum, sat);

endmodule

// File: rtl/roll_scan.sv
// Sequential lane prefix-sum: scans one LANE_W lane per clock between valid/ready stream stages,
// with wrap/saturate arithmetic and optional chaining of the previous word's final sum.
module roll_scan
  import roll_scan_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              clr
);

  localparam int LANES = DATA_W / LANE_W;
  localparam int IDX_W = idx_width(LANES);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [LANE_W-1:0]   acc;
  logic [LANE_W-1:0]   acc_n;
  logic [LANE_W-1:0]   carry;
  logic [LANE_W-1:0]   lane_cur;
  logic [DATA_W-1:0]   data_r;
  logic [1:0]          mode_r;

  always_comb begin
    lane_cur = '0;
    for (int k = 0; k < LANES; k++) begin
      if (idx == IDX_W'(k)) lane_cur = data_r[k*LANE_W +: LANE_W];
    end
  end

  roll_lane_add #(
    .LANE_W (LANE_W)
  ) u_add (
    .a   (acc),
    .b   (lane_cur),
    .sat (mode_r[MODE_SAT]),
    .y   (acc_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      data_r    <= '0;
      mode_r    <= '0;
      idx       <= '0;
      acc       <= '0;
      carry     <= '0;
    end else begin
      if (clr) carry <= '0;
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_r   <= in_data;
            mode_r   <= in_mode;
            idx      <= '0;
            // Seed uses the carry as it stood before this edge, so a same-cycle clr does not reach it.
            acc      <= in_mode[MODE_CHAIN] ? carry : '0;
            in_ready <= 1'b0;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          acc <= acc_n;
          idx <= idx + IDX_W'(1);
          for (int k = 0; k < LANES; k++) begin
            if (idx == IDX_W'(k)) out_data[k*LANE_W +: LANE_W] <= acc_n;
          end
          if (idx == IDX_W'(LANES - 1)) begin
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (!clr) carry <= acc;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_roll_scan.sv
// Scoreboard bench for roll_scan: 32/4 instance for most scenarios, 16/8 instance for wide lanes.
module tb_roll_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        clr = 1'b0;

  logic        v8 = 1'b0;
  logic        rdy8;
  logic [15:0] d8 = '0;
  logic [1:0]  m8 = '0;
  logic        ov8;
  logic        ordy8 = 1'b1;
  logic [15:0] od8;
  logic        clr8 = 1'b0;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [31:0] q[$];
  logic [3:0]  mcarry = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  roll_scan #(.DATA_W(32), .LANE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .clr(clr)
  );

  roll_scan #(.DATA_W(16), .LANE_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_data(d8),
    .in_mode(m8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .clr(clr8)
  );

  // Reference scan written lane by lane with integer arithmetic.
  function automatic logic [31:0] model_scan(input logic [31:0] d, input logic [1:0] m,
                                             input logic [3:0] seed);
    int s;
    logic [31:0] r;
    s = m[1] ? int'(seed) : 0;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      s = s + int'(d[k*4 +: 4]);
      if (s > 15) s = m[0] ? 15 : s - 16;
      r[k*4 +: 4] = 4'(s);
    end
    return r;
  endfunction

  task automatic push_model(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] e;
    e = model_scan(d, m, mcarry);
    q.push_back(e);
    mcarry = e[31:28];
  endtask

  task automatic push_const(input logic [31:0] e);
    q.push_back(e);
    mcarry = e[31:28];
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_valid = 1'b1; in_data = d; in_mode = m;
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name);
    int n = 0;
    logic [31:0] e;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!out_valid) begin
      failures++;
      $display("FAIL %s_timeout: out_valid=0 after %0d cycles, required 1", name, n);
      if (q.size() > 0) void'(q.pop_front());
    end else if (q.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected: got %h, scoreboard empty", name, out_data);
    end else begin
      e = q.pop_front();
      if (out_data !== e) begin
        failures++;
        $display("FAIL %s: out_data=%h required %h", name, out_data, e);
      end
      if (out_ready) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%h required 0 0 0",
               in_ready, out_valid, out_data);
    end
    checks++;
    if (rdy8 !== 1'b0 || ov8 !== 1'b0 || od8 !== 16'h0) begin
      failures++;
      $display("FAIL reset_state8: in_ready=%0b out_valid=%0b out_data=%h required 0 0 0",
               rdy8, ov8, od8);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%0b out_valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_sum();
    bit early = 0;
    push_const(32'h8765_4321);
    send(32'h1111_1111, 2'b00);
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) early = 1;
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL latency_early: out_valid=1 before 8 scan cycles, required 0");
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_exact: out_valid=%0b at accept+8, required 1", out_valid);
    end
    expect_out("sum_ones");
    push_const(32'h89AB_CDEF);
    send(32'hFFFF_FFFF, 2'b00);
    expect_out("sum_wrap");
    push_const(32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 2'b01);
    expect_out("sum_sat");
  endtask

  task automatic test_chain();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    mcarry = '0;
    push_const(32'h1111_1111);
    send(32'h0000_0001, 2'b10);
    expect_out("chain_first");
    push_const(32'h1111_1111);
    send(32'h0000_0000, 2'b10);
    expect_out("chain_seeded");
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    push_const(32'h0000_0000);
    send(32'h0000_0000, 2'b10);
    expect_out("chain_cleared");
    // clr landing on the DONE handshake must beat the carry update.
    push_const(32'h1111_1111);
    out_ready = 1'b0;
    send(32'h0000_0001, 2'b10);
    expect_out("chain_pre_clr");
    clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    push_const(32'h0000_0000);
    send(32'h0000_0000, 2'b10);
    expect_out("chain_clr_handshake");
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    bit bad = 0;
    out_ready = 1'b0;
    push_model(32'h0123_4567, 2'b00);
    send(32'h0123_4567, 2'b00);
    expect_out("bp_value");
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) bad = 1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: out_valid=%0b in_ready=%0b out_data=%h required 1 0 %h",
               out_valid, in_ready, out_data, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_async_reset();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    mcarry = '0;
    push_const(32'h1111_1111);
    send(32'h0000_0001, 2'b10);
    expect_out("areset_prime");
    send(32'h3333_3333, 2'b10);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL areset_outputs: out_valid=%0b out_data=%h in_ready=%0b required 0 0 0",
               out_valid, out_data, in_ready);
    end
    checks++;
    if (dut.carry !== 4'h0) begin
      failures++;
      $display("FAIL areset_carry: carry=%h required 0", dut.carry);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    mcarry = '0;
    push_const(32'h2222_2222);
    send(32'h0000_0002, 2'b10);
    expect_out("areset_next");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [1:0]  m;
    int prev;
    bit slow = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      m = 2'($urandom_range(0, 3));
      push_model(d, m);
      send(d, m);
      if (i > 0 && accept_cyc - prev != 10) slow = 1;
      prev = accept_cyc;
      expect_out("b2b");
    end
    checks++;
    if (slow) begin
      failures++;
      $display("FAIL b2b_throughput: accept spacing differs from required 10 cycles");
    end
  endtask

  task automatic test_wide_lane();
    logic [15:0] exp8[2];
    logic [1:0]  mode8[2];
    int n;
    exp8[0] = 16'h0080; exp8[1] = 16'hFF80;
    mode8[0] = 2'b00;   mode8[1] = 2'b01;
    for (int i = 0; i < 2; i++) begin
      n = 0;
      while (!rdy8 && n < 40) begin @(posedge clk); #1; n++; end
      v8 = 1'b1; d8 = 16'h8080; m8 = mode8[i];
      @(posedge clk); #1; v8 = 1'b0;
      n = 0;
      while (!ov8 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (ov8 !== 1'b1 || od8 !== exp8[i]) begin
        failures++;
        $display("FAIL wide_lane_%0d: out_valid=%0b out_data=%h required 1 %h", i, ov8, od8, exp8[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_sum();
    test_chain();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    test_wide_lane();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
